register_file: RTL and testbench

Architectural register file with per-register rename tags for the out-of-order RV32I core. It holds x0–x31 plus a busy bit and ROB tag for each register. The Instruction Unit claims a destination at issue, and the Reorder Buffer retires values at commit. Two read ports return, for each source operand, either the committed value or the ROB index of the producing entry. Those ROB indices feed the Reorder Buffer's `rs1Dep`/`rs2Dep` lookup.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/reg_file_read_port.sv | 72 +++++++
 rtl/register_file.sv | 106 ++++++++++
 tb/tb_register_file.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths and index types for the RV32I out-of-order core.
//               XLEN          - architectural data width
//               REG_IDX_WIDTH - width of an architectural register index
//               ROB_WIDTH     - width of a Reorder Buffer index
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN          = 32;
    localparam int REG_IDX_WIDTH = 5;
    localparam int NUM_REGS      = 1 << REG_IDX_WIDTH;
    localparam int ROB_WIDTH     = 4;

    typedef logic [REG_IDX_WIDTH-1:0] reg_idx_t;
    typedef logic [ROB_WIDTH-1:0]     rob_idx_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/reg_file_read_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_read_port
// Description : One source-operand read port of the register file. Selects
//               value/busy/tag by index, forces x0 to zero / not busy, and
//               (when REG_FILE_BYPASS_EN is defined) forwards a same-cycle
//               commit that retires the register's current producer.
// Ports       : rsIndex              - source register index
//               regValue/Busy/Tag    - registered file state
//               commitValid/Dest/
//               Value/RobId          - same-cycle commit (bypass only)
//               rsBusy/rsDep/rsValue - operand result
// Config      : REG_FILE_BYPASS_EN   - enables same-cycle commit bypass
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_read_port
    import riscv_pkg::*;
#(
    parameter int TAG_WIDTH = 4
) (
    input  reg_idx_t                            rsIndex,
    input  logic [NUM_REGS-1:0][XLEN-1:0]       regValue,
    input  logic [NUM_REGS-1:0]                 regBusy,
    input  logic [NUM_REGS-1:0][TAG_WIDTH-1:0]  regTag,
    input  logic                                commitValid,
    input  reg_idx_t                            commitDest,
    input  logic [XLEN-1:0]                     commitValue,
    input  logic [TAG_WIDTH-1:0]                commitRobId,
    output logic                                rsBusy,
    output logic [TAG_WIDTH-1:0]                rsDep,
    output logic [XLEN-1:0]                     rsValue
);

    logic                 w_isZero;
    logic                 w_busy;
    logic [TAG_WIDTH-1:0] w_tag;
    logic [XLEN-1:0]      w_value;
    logic                 w_bypass;

    assign w_isZero = (rsIndex == '0);
    assign w_busy   = regBusy[rsIndex];
    assign w_tag    = regTag[rsIndex];
    assign w_value  = regValue[rsIndex];

`ifdef REG_FILE_BYPASS_EN
    // Forward only when the commit retires the producer this port is waiting
    // on; a commit from an older, overwritten producer leaves the register
    // busy, so it must not be presented as ready.
    assign w_bypass = commitValid && (commitDest == rsIndex) && !w_isZero
                      && w_busy && (w_tag == commitRobId);
`else
    logic w_unusedCommit;
    assign w_unusedCommit = ^{commitValid, commitDest, commitValue, commitRobId};
    assign w_bypass       = 1'b0;
`endif

    always_comb begin
        rsBusy  = w_busy;
        rsDep   = w_tag;
        rsValue = w_value;
        if (w_isZero) begin
            rsBusy  = 1'b0;
            rsDep   = '0;
            rsValue = '0;
        end else if (w_bypass) begin
            rsBusy  = 1'b0;
            rsValue = commitValue;
        end
    end

endmodule : reg_file_read_port
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Architectural register file x0-x31 with per-register busy bit
//               and ROB rename tag. Rename claims a destination at issue,
//               commit retires a value, clear flushes all busy bits.
// Ports       : clockIn/resetIn             - clock, async active-high reset
//               clear                       - misprediction flush
//               renameValid/Dest/RobId      - destination claim
//               commitValid/Dest/Value/RobId- retirement write
//               rs1*/rs2*                   - two combinational read ports
// Config      : REG_FILE_BYPASS_EN - read ports forward same-cycle commits
// Revision    : 1.0 - initial release
// ============================================================================
module register_file
    import riscv_pkg::XLEN, riscv_pkg::NUM_REGS, riscv_pkg::reg_idx_t;
#(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 clear,
    input  logic                 renameValid,
    input  reg_idx_t             renameDest,
    input  logic [ROB_WIDTH-1:0] renameRobId,
    input  logic                 commitValid,
    input  reg_idx_t             commitDest,
    input  logic [XLEN-1:0]      commitValue,
    input  logic [ROB_WIDTH-1:0] commitRobId,
    input  reg_idx_t             rs1Index,
    output logic                 rs1Busy,
    output logic [ROB_WIDTH-1:0] rs1Dep,
    output logic [XLEN-1:0]      rs1Value,
    input  reg_idx_t             rs2Index,
    output logic                 rs2Busy,
    output logic [ROB_WIDTH-1:0] rs2Dep,
    output logic [XLEN-1:0]      rs2Value
);

    logic [NUM_REGS-1:0][XLEN-1:0]      r_value;
    logic [NUM_REGS-1:0]                r_busy;
    logic [NUM_REGS-1:0][ROB_WIDTH-1:0] r_tag;

    // Entry 0 is never written after reset, so x0 state stays zero; the read
    // ports force it regardless.
    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            r_value <= '0;
            r_busy  <= '0;
            r_tag   <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                // Retired values are architectural, so they land even on a
                // clear cycle and even when a younger rename owns the register.
                if (commitValid && (commitDest == reg_idx_t'(i))) begin
                    r_value[i] <= commitValue;
                end
                // Priority: clear > rename > matching commit. A rename in the
                // same cycle as the commit belongs to a younger instruction.
                if (clear) begin
                    r_busy[i] <= 1'b0;
                end else if (renameValid && (renameDest == reg_idx_t'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= renameRobId;
                end else if (commitValid && (commitDest == reg_idx_t'(i))
                             && (r_tag[i] == commitRobId)) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    reg_file_read_port #(
        .TAG_WIDTH (ROB_WIDTH)
    ) u_rs1Port (
        .rsIndex     (rs1Index),
        .regValue    (r_value),
        .regBusy     (r_busy),
        .regTag      (r_tag),
        .commitValid (commitValid),
        .commitDest  (commitDest),
        .commitValue (commitValue),
        .commitRobId (commitRobId),
        .rsBusy      (rs1Busy),
        .rsDep       (rs1Dep),
        .rsValue     (rs1Value)
    );

    reg_file_read_port #(
        .TAG_WIDTH (ROB_WIDTH)
    ) u_rs2Port (
        .rsIndex     (rs2Index),
        .regValue    (r_value),
        .regBusy     (r_busy),
        .regTag      (r_tag),
        .commitValid (commitValid),
        .commitDest  (commitDest),
        .commitValue (commitValue),
        .commitRobId (commitRobId),
        .rsBusy      (rs2Busy),
        .rsDep       (rs2Dep),
        .rsValue     (rs2Value)
    );

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file. Expected
//               values are hand-computed; REG_FILE_BYPASS_EN selects the
//               same-cycle commit expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int c_robWidth = 4;

    logic                  clockIn;
    logic                  resetIn;
    logic                  clear;
    logic                  renameValid;
    logic [4:0]            renameDest;
    logic [c_robWidth-1:0] renameRobId;
    logic                  commitValid;
    logic [4:0]            commitDest;
    logic [31:0]           commitValue;
    logic [c_robWidth-1:0] commitRobId;
    logic [4:0]            rs1Index;
    logic                  rs1Busy;
    logic [c_robWidth-1:0] rs1Dep;
    logic [31:0]           rs1Value;
    logic [4:0]            rs2Index;
    logic                  rs2Busy;
    logic [c_robWidth-1:0] rs2Dep;
    logic [31:0]           rs2Value;

    int checkCount = 0;
    int errorCount = 0;

    register_file #(
        .ROB_WIDTH (c_robWidth)
    ) dut (
        .clockIn     (clockIn),
        .resetIn     (resetIn),
        .clear       (clear),
        .renameValid (renameValid),
        .renameDest  (renameDest),
        .renameRobId (renameRobId),
        .commitValid (commitValid),
        .commitDest  (commitDest),
        .commitValue (commitValue),
        .commitRobId (commitRobId),
        .rs1Index    (rs1Index),
        .rs1Busy     (rs1Busy),
        .rs1Dep      (rs1Dep),
        .rs1Value    (rs1Value),
        .rs2Index    (rs2Index),
        .rs2Busy     (rs2Busy),
        .rs2Dep      (rs2Dep),
        .rs2Value    (rs2Value)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idle();
        clear       = 1'b0;
        renameValid = 1'b0;
        renameDest  = '0;
        renameRobId = '0;
        commitValid = 1'b0;
        commitDest  = '0;
        commitValue = '0;
        commitRobId = '0;
    endtask

    // Advance to just after the next rising edge and return inputs to idle.
    task automatic tick();
        @(posedge clockIn);
        #1;
        idle();
    endtask

    task automatic rename(input logic [4:0] dest, input logic [c_robWidth-1:0] id);
        renameValid = 1'b1;
        renameDest  = dest;
        renameRobId = id;
    endtask

    task automatic commit(input logic [4:0] dest, input logic [31:0] val,
                          input logic [c_robWidth-1:0] id);
        commitValid = 1'b1;
        commitDest  = dest;
        commitValue = val;
        commitRobId = id;
    endtask

    initial begin
        idle();
        resetIn  = 1'b1;
        rs1Index = 5'd5;
        rs2Index = 5'd31;
        #12;
        checkValue("reset_rs1_busy",  {31'd0, rs1Busy}, 32'd0);
        checkValue("reset_rs1_value", rs1Value,         32'd0);
        checkValue("reset_rs1_dep",   {28'd0, rs1Dep},  32'd0);
        checkValue("reset_rs2_value", rs2Value,         32'd0);
        @(negedge clockIn);
        resetIn = 1'b0;
        tick();

        // Rename x5 tag 3: old state visible in the same cycle.
        rename(5'd5, 4'd3);
        rs1Index = 5'd5;
        #1;
        checkValue("rename_same_cycle_busy", {31'd0, rs1Busy}, 32'd0);
        tick();
        checkValue("rename_busy", {31'd0, rs1Busy}, 32'd1);
        checkValue("rename_dep",  {28'd0, rs1Dep},  32'd3);

        // Younger rename tag 7; stale commit tag 3 writes value only.
        rename(5'd5, 4'd7);
        tick();
        commit(5'd5, 32'hDEAD, 4'd3);
        tick();
        checkValue("stale_commit_value", rs1Value,         32'h0000_DEAD);
        checkValue("stale_commit_busy",  {31'd0, rs1Busy}, 32'd1);
        checkValue("stale_commit_dep",   {28'd0, rs1Dep},  32'd7);
        commit(5'd5, 32'hBEEF, 4'd7);
        tick();
        checkValue("owner_commit_busy",  {31'd0, rs1Busy}, 32'd0);
        checkValue("owner_commit_value", rs1Value,         32'h0000_BEEF);

        // Rename and commit of x1 in the same cycle: rename wins busy/tag.
        rename(5'd1, 4'd2);
        tick();
        rename(5'd1, 4'd2);
        commit(5'd1, 32'h11, 4'd2);
        tick();
        rs2Index = 5'd1;
        #1;
        checkValue("rc_same_value", rs2Value,         32'h11);
        checkValue("rc_same_busy",  {31'd0, rs2Busy}, 32'd1);
        checkValue("rc_same_dep",   {28'd0, rs2Dep},  32'd2);

        // Clear with concurrent rename of x6 and commit of x3.
        rename(5'd3, 4'd5);
        tick();
        rename(5'd4, 4'd6);
        tick();
        rs1Index = 5'd3;
        rs2Index = 5'd4;
        #1;
        checkValue("pre_clear_x3_busy", {31'd0, rs1Busy}, 32'd1);
        checkValue("pre_clear_x4_busy", {31'd0, rs2Busy}, 32'd1);
        clear = 1'b1;
        rename(5'd6, 4'd8);
        commit(5'd3, 32'h42, 4'd9);
        tick();
        checkValue("clear_x3_busy",  {31'd0, rs1Busy}, 32'd0);
        checkValue("clear_x3_value", rs1Value,         32'h42);
        checkValue("clear_x4_busy",  {31'd0, rs2Busy}, 32'd0);
        rs1Index = 5'd6;
        #1;
        checkValue("clear_x6_busy", {31'd0, rs1Busy}, 32'd0);

        // x0 ignores rename and commit.
        rename(5'd0, 4'd1);
        commit(5'd0, 32'hFF, 4'd1);
        rs1Index = 5'd0;
        #1;
        checkValue("x0_same_cycle_value", rs1Value, 32'd0);
        tick();
        checkValue("x0_busy",  {31'd0, rs1Busy}, 32'd0);
        checkValue("x0_value", rs1Value,         32'd0);
        checkValue("x0_dep",   {28'd0, rs1Dep},  32'd0);

        // Commit of the current producer of x9, read in the same cycle.
        rename(5'd9, 4'd4);
        tick();
        commit(5'd9, 32'h99, 4'd4);
        rs1Index = 5'd9;
        #1;
`ifdef REG_FILE_BYPASS_EN
        checkValue("bypass_busy",  {31'd0, rs1Busy}, 32'd0);
        checkValue("bypass_value", rs1Value,         32'h99);
`else
        checkValue("nobypass_busy",  {31'd0, rs1Busy}, 32'd1);
        checkValue("nobypass_value", rs1Value,         32'd0);
`endif
        tick();
        checkValue("x9_after_busy",  {31'd0, rs1Busy}, 32'd0);
        checkValue("x9_after_value", rs1Value,         32'h99);

        // Commit from a non-owning tag is never forwarded.
        rename(5'd10, 4'd2);
        tick();
        commit(5'd10, 32'hAA, 4'd3);
        rs2Index = 5'd10;
        #1;
        checkValue("wrongtag_same_busy",  {31'd0, rs2Busy}, 32'd1);
        checkValue("wrongtag_same_value", rs2Value,         32'd0);
        tick();
        checkValue("wrongtag_after_busy",  {31'd0, rs2Busy}, 32'd1);
        checkValue("wrongtag_after_value", rs2Value,         32'hAA);
        checkValue("wrongtag_after_dep",   {28'd0, rs2Dep},  32'd2);

        // Earlier registers left untouched by later traffic.
        rs1Index = 5'd5;
        #1;
        checkValue("x5_retained_value", rs1Value, 32'h0000_BEEF);

        // Asynchronous reset mid-run clears state without a clock edge.
        @(negedge clockIn);
        resetIn = 1'b1;
        #1;
        checkValue("async_reset_x5_value", rs1Value,         32'd0);
        checkValue("async_reset_x10_busy", {31'd0, rs2Busy}, 32'd0);
        resetIn = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule : tb_register_file
`default_nettype wire
